weapons_bank: RTL and testbench



---
 rtl/weapons_bank.sv | 101 ++++++++++
 tb/tb_weapons_bank.sv | 120 ++++++++++++
 2 files changed

// File: rtl/weapons_bank.sv
// weapons_bank: multi-channel ammo bank with fire/cooldown/reload FSM.
// Channel i's ammo is packed at ammo[i*W +: W]; fired/error are one-cycle registered pulses.
module weapons_bank #(
    parameter int         CH          = 2,
    parameter int         W           = 9,
    parameter int         SEL_W       = 1,
    parameter int         COOLDOWN    = 4,
    parameter int         RELOAD_STEP = 16,
    parameter logic [3:0] ATTACK_MODE = 4'b0010
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      mode,
    input  logic [SEL_W-1:0] sel,
    input  logic            fire,
    input  logic            reload,
    input  logic [W-1:0]    cost,
    input  logic            max_load,
    input  logic [W-1:0]    max_val,
    output logic [CH*W-1:0] ammo,
    output logic            fired,
    output logic            error,
    output logic [1:0]      state
);
    localparam int CW = COOLDOWN > 1 ? $clog2(COOLDOWN + 1) : 1;
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_COOL = 2'b01, S_RELOAD = 2'b10} state_t;
    state_t           r_state;
    logic [W-1:0]     r_ammo [CH];
    logic [W-1:0]     r_max  [CH];
    logic [CW-1:0]    r_cnt;
    logic [SEL_W-1:0] r_ch;
    logic             r_fired, r_error;
    logic             w_ok, w_shot_ok;
    logic [W-1:0]     w_a, w_m, w_fill;
    logic [W:0]       w_sum;
    // Selects beyond CH read as an empty, zero-capacity channel so they can never be serviced.
    always_comb begin
        w_ok      = int'(sel) < CH;
        w_a       = w_ok ? r_ammo[sel] : '0;
        w_m       = w_ok ? r_max[sel] : '0;
        w_shot_ok = mode == ATTACK_MODE && cost != '0 && w_a >= cost;
        w_sum     = {1'b0, r_ammo[r_ch]} + (W+1)'(RELOAD_STEP);
        w_fill    = w_sum >= {1'b0, r_max[r_ch]} ? r_max[r_ch] : w_sum[W-1:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                r_ammo[i] <= '0;
                r_max[i]  <= '1;
            end
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ch    <= '0;
            r_fired <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_fired <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE:
                    if (reload) begin
                        if (w_a < w_m) begin
                            r_ch    <= sel;
                            r_state <= S_RELOAD;
                        end
                    end else if (max_load) begin
                        if (w_ok) begin
                            r_max[sel] <= max_val;
                            if (r_ammo[sel] > max_val) r_ammo[sel] <= max_val;
                        end
                    end else if (fire) begin
                        if (w_shot_ok) begin
                            r_ammo[sel] <= w_a - cost;
                            r_fired     <= 1'b1;
                            if (COOLDOWN > 0) begin
                                r_state <= S_COOL;
                                r_cnt   <= CW'(COOLDOWN - 1);
                            end
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                S_COOL:
                    if (r_cnt == '0) r_state <= S_IDLE;
                    else r_cnt <= r_cnt - 1'b1;
                S_RELOAD: begin
                    r_ammo[r_ch] <= w_fill;
                    r_error      <= fire;
                    if (w_fill == r_max[r_ch]) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    for (genvar i = 0; i < CH; i++) begin : g_pack
        assign ammo[i*W +: W] = r_ammo[i];
    end
    assign fired = r_fired;
    assign error = r_error;
    assign state = r_state;
endmodule

// File: tb/tb_weapons_bank.sv
// tb_weapons_bank: directed vector table plus hand sequences for weapons_bank.
module tb_weapons_bank;
    logic        clk = 1'b0;
    logic        rst, fire, reload, max_load;
    logic [3:0]  mode;
    logic [0:0]  sel;
    logic [8:0]  cost, max_val;
    logic [17:0] ammo;
    logic        fired, error;
    logic [1:0]  state;
    int          n_pass = 0, n_total = 0;

    weapons_bank dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel), .fire(fire), .reload(reload),
        .cost(cost), .max_load(max_load), .max_val(max_val),
        .ammo(ammo), .fired(fired), .error(error), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst; logic [3:0] mode; logic sel; logic fire; logic reload;
        logic [8:0] cost; logic ml; logic [8:0] mv;
        int a0; int a1; logic f; logic e; logic [1:0] st;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic [3:0] m, input logic s, input logic f,
                         input logic rl, input logic [8:0] c, input logic ml, input logic [8:0] mv);
        rst = r; mode = m; sel = s; fire = f; reload = rl; cost = c; max_load = ml; max_val = mv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 2, 0, 0, 0, 5, 0, 0);
        // rst, mode, sel, fire, reload, cost, max_load, max_val -> ammo0, ammo1, fired, error, state
        tv.push_back('{1, 2, 0, 0, 0, 5, 0, 0,     0, 0, 0, 0, 0});
        tv.push_back('{0, 2, 0, 0, 0, 5, 1, 40,    0, 0, 0, 0, 0});
        tv.push_back('{0, 2, 0, 0, 1, 5, 0, 0,     0, 0, 0, 0, 2});
        tv.push_back('{0, 2, 1, 0, 0, 5, 0, 0,    16, 0, 0, 0, 2});
        tv.push_back('{0, 1, 1, 0, 1, 5, 0, 0,    32, 0, 0, 0, 2});
        tv.push_back('{0, 2, 0, 0, 0, 5, 0, 0,    40, 0, 0, 0, 0});
        tv.push_back('{0, 2, 0, 1, 0, 5, 0, 0,    35, 0, 1, 0, 1});
        tv.push_back('{0, 2, 0, 1, 0, 5, 0, 0,    35, 0, 0, 0, 1});
        tv.push_back('{0, 2, 0, 1, 0, 5, 0, 0,    35, 0, 0, 0, 1});
        tv.push_back('{0, 2, 0, 1, 0, 5, 0, 0,    35, 0, 0, 0, 1});
        tv.push_back('{0, 2, 0, 1, 0, 5, 0, 0,    35, 0, 0, 0, 0});
        tv.push_back('{0, 2, 0, 1, 0, 5, 0, 0,    30, 0, 1, 0, 1});
        tv.push_back('{0, 2, 0, 0, 0, 5, 0, 0,    30, 0, 0, 0, 1});
        tv.push_back('{0, 2, 0, 0, 0, 5, 0, 0,    30, 0, 0, 0, 1});
        tv.push_back('{0, 2, 0, 0, 0, 5, 0, 0,    30, 0, 0, 0, 1});
        tv.push_back('{0, 2, 0, 0, 0, 5, 0, 0,    30, 0, 0, 0, 0});
        tv.push_back('{0, 1, 0, 1, 0, 5, 0, 0,    30, 0, 0, 1, 0});
        tv.push_back('{0, 2, 1, 0, 0, 5, 1, 3,    30, 0, 0, 0, 0});
        tv.push_back('{0, 2, 1, 0, 1, 5, 0, 0,    30, 0, 0, 0, 2});
        tv.push_back('{0, 2, 1, 0, 0, 5, 0, 0,    30, 3, 0, 0, 0});
        tv.push_back('{0, 2, 1, 1, 0, 5, 0, 0,    30, 3, 0, 1, 0});
        tv.push_back('{0, 2, 0, 1, 0, 0, 0, 0,    30, 3, 0, 1, 0});
        tv.push_back('{0, 2, 0, 0, 0, 5, 1, 25,   25, 3, 0, 0, 0});
        tv.push_back('{0, 2, 0, 0, 1, 5, 0, 0,    25, 3, 0, 0, 0});
        tv.push_back('{0, 2, 0, 0, 0, 5, 1, 100,  25, 3, 0, 0, 0});
        tv.push_back('{0, 2, 0, 1, 1, 5, 0, 0,    25, 3, 0, 0, 2});
        tv.push_back('{0, 2, 0, 1, 0, 5, 0, 0,    41, 3, 0, 1, 2});
        tv.push_back('{1, 2, 0, 1, 1, 5, 0, 0,     0, 0, 0, 0, 0});
        tv.push_back('{0, 2, 0, 0, 1, 5, 0, 0,     0, 0, 0, 0, 2});
        tv.push_back('{0, 2, 0, 0, 0, 5, 0, 0,    16, 0, 0, 0, 2});
        tv.push_back('{1, 2, 0, 0, 0, 5, 0, 0,     0, 0, 0, 0, 0});
        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].mode, tv[i].sel, tv[i].fire, tv[i].reload, tv[i].cost, tv[i].ml, tv[i].mv);
            step();
            chk($sformatf("v%0d ammo0", i), int'(ammo[8:0]), tv[i].a0);
            chk($sformatf("v%0d ammo1", i), int'(ammo[17:9]), tv[i].a1);
            chk($sformatf("v%0d fired", i), int'(fired), int'(tv[i].f));
            chk($sformatf("v%0d error", i), int'(error), int'(tv[i].e));
            chk($sformatf("v%0d state", i), int'(state), int'(tv[i].st));
        end
        // Reload to a small cap with a bounded wait, then reset in the middle of cooldown.
        drive(0, 2, 0, 0, 0, 7, 1, 20);
        step();
        drive(0, 2, 0, 0, 1, 7, 0, 0);
        step();
        chk("seq reload_enter", int'(state), 2);
        drive(0, 2, 0, 0, 0, 7, 0, 0);
        begin
            int n = 0;
            while (state != 2'b00 && n < 10) begin
                step();
                n++;
            end
            chk("seq reload_timeout", int'(n < 10), 1);
            chk("seq reload_cycles", n, 2);
        end
        chk("seq ammo0_full", int'(ammo[8:0]), 20);
        drive(0, 2, 0, 1, 0, 7, 0, 0);
        step();
        chk("seq shot_ammo0", int'(ammo[8:0]), 13);
        chk("seq shot_fired", int'(fired), 1);
        chk("seq shot_state", int'(state), 1);
        drive(0, 2, 0, 0, 0, 7, 0, 0);
        step();
        drive(1, 2, 0, 1, 0, 7, 0, 0);
        step();
        chk("seq rst_cool_state", int'(state), 0);
        chk("seq rst_cool_ammo0", int'(ammo[8:0]), 0);
        chk("seq rst_cool_fired", int'(fired), 0);
        chk("seq rst_cool_error", int'(error), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
